// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: transmit byte FIFO plus frame launcher for the UART transmitter.
// Buffers host bytes, pops one per frame, holds tx_data and frame config stable
// until tx_done, and aborts a frame through a watchdog if tx_done never arrives.
module uart_tx_fifo_ctrl #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic                       tx_clk,
  input  logic                       rst,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 cfg_length,
  input  logic                       cfg_parity_type,
  input  logic                       cfg_parity_en,
  input  logic                       cfg_stop2,
  input  logic                       clr_err,
  input  logic                       tx_done,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic [3:0]                 length,
  output logic                       parity_type,
  output logic                       parity_en,
  output logic                       stop2,
  output logic [$clog2(DEPTH):0]     fifo_level,
  output logic                       busy,
  output logic                       err_timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    GAP    = 2'd3
  } state_e;

  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [LW-1:0]   level_d;
  logic            in_ready_q;
  logic            tx_start_q;
  logic [7:0]      tx_data_q;
  logic [3:0]      length_q;
  logic            parity_type_q;
  logic            parity_en_q;
  logic            stop2_q;
  logic            busy_q;
  logic            err_q;
  logic [WW-1:0]   wd_q;
  logic [GW-1:0]   gap_q;

  logic            push_c;
  logic            pop_c;
  logic [3:0]      length_san_c;

  // Handshake and pop qualification; a full FIFO refuses pushes regardless of a same-cycle pop.
  assign push_c       = in_valid && in_ready_q;
  assign pop_c        = (state_q == IDLE) && (level_q != '0);
  assign level_d      = level_q + LW'(push_c) - LW'(pop_c);
  assign length_san_c = ((cfg_length >= 4'd5) && (cfg_length <= 4'd8)) ? cfg_length : 4'd8;

  // Byte storage; contents need no reset since the pointers define validity.
  always_ff @(posedge tx_clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers, occupancy and registered ready.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q    <= level_d;
      in_ready_q <= (level_d != LW'(DEPTH));
    end
  end

  // Frame launcher FSM with watchdog, inter-frame gap and latched frame config.
  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      length_q      <= 4'd8;
      parity_type_q <= 1'b0;
      parity_en_q   <= 1'b0;
      stop2_q       <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      wd_q          <= '0;
      gap_q         <= '0;
    end else begin
      // Clear first so a timeout later in this block takes precedence.
      if (clr_err) begin
        err_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (pop_c) begin
            state_q       <= LAUNCH;
            busy_q        <= 1'b1;
            tx_start_q    <= 1'b1;
            tx_data_q     <= mem_q[rd_ptr_q];
            length_q      <= length_san_c;
            parity_type_q <= cfg_parity_type;
            parity_en_q   <= cfg_parity_en;
            stop2_q       <= cfg_stop2;
          end
        end
        LAUNCH: begin
          state_q    <= BUSY;
          tx_start_q <= 1'b0;
          wd_q       <= '0;
        end
        BUSY: begin
          if (tx_done) begin
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              gap_q   <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else if (wd_q == WW'(TIMEOUT - 1)) begin
            // Transmitter hung: drop the byte and flag it.
            state_q <= IDLE;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign length      = length_q;
  assign parity_type = parity_type_q;
  assign parity_en   = parity_en_q;
  assign stop2       = stop2_q;
  assign fifo_level  = level_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: scoreboarded launches on a back-to-back instance,
// plus a second instance with a 4-cycle inter-frame gap.
module tb_uart_tx_fifo_ctrl;

  logic       tx_clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic [3:0] cfg_length;
  logic       cfg_parity_type;
  logic       cfg_parity_en;
  logic       cfg_stop2;
  logic       clr_err;
  logic       tx_done;

  logic       in_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] length;
  logic       parity_type;
  logic       parity_en;
  logic       stop2;
  logic [4:0] fifo_level;
  logic       busy;
  logic       err_timeout;

  logic       g_in_valid;
  logic       g_tx_done;
  logic       g_in_ready;
  logic       g_tx_start;
  logic [7:0] g_tx_data;
  logic [3:0] g_length;
  logic       g_parity_type;
  logic       g_parity_en;
  logic       g_stop2;
  logic [4:0] g_fifo_level;
  logic       g_busy;
  logic       g_err_timeout;

  always #5 tx_clk = ~tx_clk;

  uart_tx_fifo_ctrl #(.DEPTH(16), .GAP_CYCLES(0), .TIMEOUT(32)) u_dut (
    .tx_clk(tx_clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .cfg_length(cfg_length), .cfg_parity_type(cfg_parity_type), .cfg_parity_en(cfg_parity_en),
    .cfg_stop2(cfg_stop2), .clr_err(clr_err), .tx_done(tx_done), .tx_start(tx_start),
    .tx_data(tx_data), .length(length), .parity_type(parity_type), .parity_en(parity_en),
    .stop2(stop2), .fifo_level(fifo_level), .busy(busy), .err_timeout(err_timeout)
  );

  uart_tx_fifo_ctrl #(.DEPTH(16), .GAP_CYCLES(4), .TIMEOUT(32)) u_gap (
    .tx_clk(tx_clk), .rst(rst), .in_data(in_data), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .cfg_length(cfg_length), .cfg_parity_type(cfg_parity_type), .cfg_parity_en(cfg_parity_en),
    .cfg_stop2(cfg_stop2), .clr_err(clr_err), .tx_done(g_tx_done), .tx_start(g_tx_start),
    .tx_data(g_tx_data), .length(g_length), .parity_type(g_parity_type), .parity_en(g_parity_en),
    .stop2(g_stop2), .fifo_level(g_fifo_level), .busy(g_busy), .err_timeout(g_err_timeout)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;
  int         launch_cnt = 0;
  logic       prev_start = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard: every launch must carry the oldest accepted byte, for one cycle only.
  always @(negedge tx_clk) begin
    if (tx_start === 1'b1) begin
      chk("start_one_cycle", 32'(prev_start), 32'd0);
      chk("launch_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("launch_data", 32'(tx_data), 32'(exp_q.pop_front()));
      last_byte = tx_data;
      launch_cnt++;
    end
    prev_start = (tx_start === 1'b1);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge tx_clk);
  endtask

  // Push one byte into u_dut; starts and returns on a negedge.
  task automatic push(input logic [7:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin
      tick();
      t++;
    end
    if (!in_ready) begin
      chk("push_ready_wait", 32'(in_ready), 32'd1);
      return;
    end
    in_data  = b;
    in_valid = 1'b1;
    @(posedge tx_clk);
    exp_q.push_back(b);
    @(negedge tx_clk);
    in_valid = 1'b0;
  endtask

  // Wait for BUSY, check the byte is still held, pulse tx_done; returns in the cycle after the done edge.
  task automatic complete_frame();
    int t = 0;
    while (!(busy && !tx_start) && t < 100) begin
      tick();
      t++;
    end
    if (!(busy && !tx_start)) begin
      chk("frame_busy_wait", 32'(busy), 32'd1);
      return;
    end
    chk("data_held", 32'(tx_data), 32'(last_byte));
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic check_reset_vals(input string pre);
    chk({pre, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({pre, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({pre, "_tx_data"}, 32'(tx_data), 32'h00);
    chk({pre, "_length"}, 32'(length), 32'd8);
    chk({pre, "_cfg_bits"}, 32'({parity_type, parity_en, stop2}), 32'd0);
    chk({pre, "_level"}, 32'(fifo_level), 32'd0);
    chk({pre, "_busy"}, 32'(busy), 32'd0);
    chk({pre, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int c;
    int cnt;
    rst = 1'b0; in_data = 8'h00; in_valid = 1'b0; cfg_length = 4'd8;
    cfg_parity_type = 1'b0; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    clr_err = 1'b0; tx_done = 1'b0; g_in_valid = 1'b0; g_tx_done = 1'b0;
    #1 rst = 1'b1;
    #1 check_reset_vals("rst0");
    tick(2);
    rst = 1'b0;
    tick(2);

    // Single byte
    push(8'hA5);
    chk("single_level_n", 32'(fifo_level), 32'd1);
    chk("single_start_n", 32'(tx_start), 32'd0);
    tick();
    chk("single_start_n1", 32'(tx_start), 32'd1);
    chk("single_busy_n1", 32'(busy), 32'd1);
    chk("single_level_n1", 32'(fifo_level), 32'd0);
    tick();
    chk("single_start_n2", 32'(tx_start), 32'd0);
    chk("single_data_n2", 32'(tx_data), 32'hA5);
    tick(3);
    complete_frame();
    chk("single_idle", 32'(busy), 32'd0);
    chk("single_data_after", 32'(tx_data), 32'hA5);
    tick(2);

    // Burst to full with tx_done withheld
    for (int i = 0; i < 17; i++) push(8'(i));
    chk("burst_ready_full", 32'(in_ready), 32'd0);
    chk("burst_level_full", 32'(fifo_level), 32'd16);
    in_data = 8'h11; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("burst_refuse_level", 32'(fifo_level), 32'd16);
    for (int k = 0; k < 17; k++) begin
      complete_frame();
      chk("b2b_idle", 32'(busy), 32'd0);
      if (k < 16) begin
        tick();
        chk("b2b_launch", 32'(tx_start), 32'd1);
        if (k == 0) begin
          chk("burst_ready_back", 32'(in_ready), 32'd1);
          chk("burst_level_15", 32'(fifo_level), 32'd15);
        end
      end
    end
    chk("burst_level_empty", 32'(fifo_level), 32'd0);
    chk("burst_sb_empty", 32'(exp_q.size()), 32'd0);
    tick(2);

    // Watchdog timeout
    push(8'h3C);
    tick(33);
    chk("to_err_before", 32'(err_timeout), 32'd0);
    chk("to_busy_before", 32'(busy), 32'd1);
    chk("to_data_held", 32'(tx_data), 32'h3C);
    tick();
    chk("to_err_set", 32'(err_timeout), 32'd1);
    chk("to_busy_idle", 32'(busy), 32'd0);
    tick(2);
    chk("to_err_sticky", 32'(err_timeout), 32'd1);
    chk("to_level", 32'(fifo_level), 32'd0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("to_err_cleared", 32'(err_timeout), 32'd0);
    tick(2);

    // Config latch and sanitise
    cfg_length = 4'd3; cfg_parity_type = 1'b1; cfg_parity_en = 1'b1; cfg_stop2 = 1'b1;
    push(8'h5A);
    tick();
    chk("cfg_len_sanitised", 32'(length), 32'd8);
    chk("cfg_bits_latched", 32'({parity_type, parity_en, stop2}), 32'd7);
    cfg_length = 4'd6; cfg_parity_type = 1'b0; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    push(8'h6B);
    tick(2);
    chk("cfg_len_hold", 32'(length), 32'd8);
    chk("cfg_bits_hold", 32'({parity_type, parity_en, stop2}), 32'd7);
    complete_frame();
    tick();
    chk("cfg_len_new", 32'(length), 32'd6);
    chk("cfg_bits_new", 32'({parity_type, parity_en, stop2}), 32'd0);
    complete_frame();
    cfg_length = 4'd8;
    tick(2);

    // Reset mid-frame
    push(8'h91); push(8'h92); push(8'h93); push(8'h94);
    chk("mid_level", 32'(fifo_level), 32'd3);
    chk("mid_busy", 32'(busy), 32'd1);
    #1 rst = 1'b1;
    #1 check_reset_vals("rst_mid");
    @(posedge tx_clk);
    @(negedge tx_clk);
    rst = 1'b0;
    exp_q.delete();
    cnt = launch_cnt;
    tick(10);
    chk("rst_no_launch", 32'(launch_cnt), 32'(cnt));
    chk("rst_still_idle", 32'(busy), 32'd0);
    push(8'hC3);
    tick();
    chk("rst_new_launch", 32'(tx_start), 32'd1);
    complete_frame();
    tick(2);

    // Inter-frame gap on the GAP_CYCLES=4 instance
    in_data = 8'hE1; g_in_valid = 1'b1;
    tick();
    in_data = 8'hE2;
    tick();
    g_in_valid = 1'b0;
    chk("gap_first_start", 32'(g_tx_start), 32'd1);
    chk("gap_first_data", 32'(g_tx_data), 32'hE1);
    tick();
    g_tx_done = 1'b1;
    tick();
    g_tx_done = 1'b0;
    chk("gap_busy_in_gap", 32'(g_busy), 32'd1);
    c = 0;
    while (!g_tx_start && c < 20) begin
      tick();
      c++;
      if (c == 4) begin
        chk("gap_idle_cycle", 32'(g_busy), 32'd0);
        chk("gap_data_held", 32'(g_tx_data), 32'hE1);
      end
    end
    chk("gap_cycles_to_start", 32'(c), 32'd5);
    chk("gap_second_data", 32'(g_tx_data), 32'hE2);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
# uart_tx_fifo_ctrl

Transmit-side byte buffer and frame launcher that sits directly upstream of the UART transmitter. It accepts bytes from a host valid/ready interface into a FIFO, pops one byte per frame, and drives the transmitter's `tx_start`, `tx_data` and frame-config inputs. It holds those inputs stable until the transmitter reports `tx_done`, and a watchdog recovers from a transmitter that never completes.

## Interface
- `DEPTH`, 16: FIFO entries; power of 2, ≥2.
- `GAP_CYCLES`, 0: idle cycles inserted after each `tx_done` before the next launch; 0 = back-to-back.
- `TIMEOUT`, 32: max BUSY cycles without `tx_done` before abort; must be ≥16.
- `tx_clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_data`  in  8  host byte.
- `in_valid`  in  1  host byte valid.
- `in_ready`  out  1  FIFO can accept a byte (= !full).
- `cfg_length`  in  4  data bits per frame; legal 5..8.
- `cfg_parity_type`, `cfg_parity_en`, `cfg_stop2`  in  1 each  frame config.
- `clr_err`  in  1  clears `err_timeout`.
- `tx_done`  in  1  from transmitter; 1-cycle completion pulse.
- `tx_start`  out  1  launch pulse to transmitter.
- `tx_data`  out  8  byte being transmitted (registered).
- `length`  out  4; `parity_type`, `parity_en`, `stop2`  out  1 each: latched frame config.
- `fifo_level`  out  $clog2(DEPTH)+1  current occupancy.
- `busy`  out  1  state != IDLE.
- `err_timeout`  out  1  sticky watchdog abort flag.

## Operation
- FIFO: push on `in_valid && in_ready`. A push is refused when full, even if a pop occurs the same cycle. Pointers wrap modulo DEPTH. `fifo_level` = pushes − pops.
- FSM states: IDLE, LAUNCH, BUSY, GAP.
- IDLE: if `fifo_level` > 0 at the edge, pop the head into `tx_data` and latch `cfg_*` into the config outputs, then go to LAUNCH.
- Length sanitising: if `cfg_length` is outside 5..8, `length` latches 8.
- LAUNCH: `tx_start` = 1 for exactly this one cycle; next edge goes to BUSY.
- BUSY: watchdog counts up from 0.
  - `tx_done` = 1 sampled: go to GAP if GAP_CYCLES > 0, else IDLE.
  - Watchdog reaches TIMEOUT−1 without `tx_done`: set `err_timeout`, discard the byte (no retry), go to IDLE.
- GAP: counts GAP_CYCLES cycles, then goes to IDLE.
- `tx_done` outside BUSY is ignored.
- `tx_data` and config outputs change only on the IDLE→LAUNCH edge and stay stable through LAUNCH, BUSY and GAP.
- `cfg_*` changes mid-frame have no effect until the next pop.
- `err_timeout`: set by a timeout; cleared by `clr_err` or `rst`. If both occur in the same cycle, set wins.
- Pushes are accepted in every FSM state.

## Timing
- Reset values:
  - `in_ready`=1, `tx_start`=0, `tx_data`=0x00, `length`=8.
  - `parity_type`=`parity_en`=`stop2`=0.
  - `fifo_level`=0, `busy`=0, `err_timeout`=0; FSM in IDLE; FIFO emptied.
- Push at edge N into an empty FIFO in IDLE:
  - Edge N+1: pop, state LAUNCH; `tx_start`=1 during cycle N+1.
  - Edge N+2: BUSY.
- Back-to-back frames (GAP_CYCLES=0): `tx_done` sampled at edge M puts the FSM in IDLE; the next pop occurs at edge M+1 and `tx_start` is high in cycle M+1.
- `in_ready` deasserts in the cycle after the push that makes `fifo_level`=DEPTH. It reasserts in the cycle after the next pop.
- `rst` asserted mid-frame: all outputs go to reset values immediately (async). Queued bytes are lost; no partial-frame completion.
- Single-entry case: push and pop in the same edge from an empty FIFO is not possible; pop needs `fifo_level`>0 before the edge.

## Test plan
- Single byte: push 0xA5 with cfg_length=8 → `tx_start` pulses one cycle at N+1, `tx_data`=0xA5 held until `tx_done`, `fifo_level` returns to 0.
- Burst/full: push 17 bytes 0x00..0x10 with `tx_done` withheld → `in_ready`=0 at `fifo_level`=16. On each `tx_done`, bytes emerge in order 0x00,0x01,…; the push of 0x10 is accepted only after the first pop.
- Timeout: push 0x3C, never assert `tx_done` → `err_timeout`=1 after 32 BUSY cycles, FSM returns to IDLE; `clr_err` clears it.
- Config latch/sanitise: cfg_length=3 at pop → `length`=8. Changing cfg_length to 6 mid-frame leaves `length`=8 until the next pop, which latches 6.
- Gap: GAP_CYCLES=4, two queued bytes → 4 idle cycles between `tx_done` and the second `tx_start`, plus 1 IDLE cycle.
- Reset mid-frame: assert `rst` in BUSY with 3 bytes queued → `tx_start`=0, `fifo_level`=0, `busy`=0 immediately; no launch after release until a new push.
